// File: rtl/mac_pe_acc.sv
// Systolic-array processing element: weight-stationary psum chain or output-stationary
// local accumulation, with round/shift/saturate requantisation and a sticky overflow flag.
module mac_pe_acc #(
    parameter int DATA_W  = 8,
    parameter int ACC_W   = 24,
    parameter int SHIFT_W = 5
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               mode_os_i,
    input  logic               load_w_i,
    input  logic               clear_acc_i,
    input  logic               drain_i,
    input  logic               sat_en_i,
    input  logic [SHIFT_W-1:0] shift_i,
    input  logic [DATA_W-1:0]  north_i,
    input  logic               north_valid_i,
    input  logic [DATA_W-1:0]  west_i,
    input  logic               west_valid_i,
    input  logic [ACC_W-1:0]   psum_i,
    input  logic               psum_valid_i,
    output logic [DATA_W-1:0]  east_o,
    output logic               east_valid_o,
    output logic [DATA_W-1:0]  south_o,
    output logic               south_valid_o,
    output logic [ACC_W-1:0]   psum_o,
    output logic               psum_valid_o,
    output logic [DATA_W-1:0]  result_o,
    output logic               result_valid_o,
    output logic               ovf_o
);
    localparam int PROD_W = 2 * DATA_W;
    localparam int D_MAX  = 2 ** (DATA_W - 1) - 1;
    localparam int D_MIN  = -(2 ** (DATA_W - 1));
    localparam logic signed [ACC_W-1:0] ACC_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] ACC_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic signed [DATA_W-1:0] r_weight;
    logic signed [ACC_W-1:0]  r_acc;
    logic [DATA_W-1:0]        r_east, r_south, r_result;
    logic [ACC_W-1:0]         r_psum;
    logic                     r_east_v, r_south_v, r_psum_v, r_result_v, r_ovf;

    logic signed [PROD_W-1:0] w_prod_ws, w_prod_os;
    logic signed [ACC_W-1:0]  w_ws_sum, w_os_sum;
    logic                     w_ws_clamp, w_os_clamp;
    logic [DATA_W-1:0]        w_rq_ws, w_rq_os;
    logic                     w_rq_ws_clamp, w_rq_os_clamp;
    logic                     w_ws_fire, w_os_fire, w_ovf_set;

    function automatic void sat_add(input logic signed [ACC_W-1:0] a,
                                    input logic signed [ACC_W-1:0] b,
                                    output logic signed [ACC_W-1:0] y,
                                    output logic clamp);
        logic signed [ACC_W:0] s;
        s     = (ACC_W+1)'(a) + (ACC_W+1)'(b);
        clamp = s[ACC_W] != s[ACC_W-1];
        y     = clamp ? (s[ACC_W] ? ACC_MIN : ACC_MAX) : s[ACC_W-1:0];
    endfunction

    // Shifts beyond ACC_W always round to 0, so the amount is capped to keep the bias in range.
    function automatic void requant(input logic signed [ACC_W-1:0] x,
                                    input logic [SHIFT_W-1:0] shift,
                                    input logic sat,
                                    output logic [DATA_W-1:0] y,
                                    output logic clamp);
        logic signed [ACC_W:0] xe;
        logic signed [ACC_W:0] r;
        int sh;
        sh = (int'(shift) > ACC_W) ? ACC_W : int'(shift);
        xe = (ACC_W+1)'(x);
        if (sh == 0) r = xe;
        else         r = (xe + ((ACC_W+1)'(1) <<< (sh - 1))) >>> sh;
        clamp = 1'b0;
        y     = r[DATA_W-1:0];
        if (sat && r > (ACC_W+1)'(D_MAX)) begin
            clamp = 1'b1;
            y     = DATA_W'(D_MAX);
        end else if (sat && r < (ACC_W+1)'(D_MIN)) begin
            clamp = 1'b1;
            y     = DATA_W'(D_MIN);
        end
    endfunction

    assign w_prod_ws = PROD_W'($signed(r_weight)) * PROD_W'($signed(west_i));
    assign w_prod_os = PROD_W'($signed(north_i)) * PROD_W'($signed(west_i));
    assign w_ws_fire = west_valid_i & psum_valid_i;
    assign w_os_fire = west_valid_i & north_valid_i;

    always_comb begin
        sat_add($signed(psum_i), ACC_W'(w_prod_ws), w_ws_sum, w_ws_clamp);
        sat_add(r_acc, ACC_W'(w_prod_os), w_os_sum, w_os_clamp);
        requant(w_ws_sum, shift_i, sat_en_i, w_rq_ws, w_rq_ws_clamp);
        requant(r_acc, shift_i, sat_en_i, w_rq_os, w_rq_os_clamp);
    end

    // Only clamps that actually reach a register count towards the sticky flag.
    assign w_ovf_set = mode_os_i
        ? ((w_os_fire & ~drain_i & ~clear_acc_i & w_os_clamp) | (drain_i & w_rq_os_clamp))
        : (w_ws_fire & (w_ws_clamp | (drain_i & w_rq_ws_clamp)));

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_weight   <= '0;
            r_acc      <= '0;
            r_east     <= '0;
            r_east_v   <= 1'b0;
            r_south    <= '0;
            r_south_v  <= 1'b0;
            r_psum     <= '0;
            r_psum_v   <= 1'b0;
            r_result   <= '0;
            r_result_v <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            r_east     <= west_i;
            r_east_v   <= west_valid_i;
            r_south    <= north_i;
            r_south_v  <= north_valid_i;
            r_result_v <= 1'b0;
            if (load_w_i && north_valid_i)
                r_weight <= north_i;
            if (!mode_os_i) begin
                if (clear_acc_i)
                    r_acc <= '0;
                r_psum_v <= w_ws_fire;
                if (w_ws_fire) begin
                    r_psum <= w_ws_sum;
                    if (drain_i) begin
                        r_result   <= w_rq_ws;
                        r_result_v <= 1'b1;
                    end
                end
            end else begin
                r_psum   <= psum_i;
                r_psum_v <= psum_valid_i;
                if (drain_i) begin
                    r_result   <= w_rq_os;
                    r_result_v <= 1'b1;
                end
                // Drain/clear with a fire seeds the next tile directly with the product.
                if (drain_i || clear_acc_i)
                    r_acc <= w_os_fire ? ACC_W'(w_prod_os) : '0;
                else if (w_os_fire)
                    r_acc <= w_os_sum;
            end
            if (w_ovf_set)
                r_ovf <= 1'b1;
            else if (clear_acc_i)
                r_ovf <= 1'b0;
        end
    end

    assign east_o         = r_east;
    assign east_valid_o   = r_east_v;
    assign south_o        = r_south;
    assign south_valid_o  = r_south_v;
    assign psum_o         = r_psum;
    assign psum_valid_o   = r_psum_v;
    assign result_o       = r_result;
    assign result_valid_o = r_result_v;
    assign ovf_o          = r_ovf;
endmodule

// File: tb/tb_mac_pe_acc.sv
// Directed table-driven bench for mac_pe_acc plus hand sequences for multi-cycle corners.
module tb_mac_pe_acc;
    logic        clk = 1'b0;
    logic        rst_i, mode_os_i, load_w_i, clear_acc_i, drain_i, sat_en_i;
    logic [4:0]  shift_i;
    logic [7:0]  north_i, west_i;
    logic        north_valid_i, west_valid_i, psum_valid_i;
    logic [23:0] psum_i;
    logic [7:0]  east_o, south_o, result_o;
    logic        east_valid_o, south_valid_o, psum_valid_o, result_valid_o, ovf_o;
    logic [23:0] psum_o;
    int          n_pass = 0;
    int          n_total = 0;

    mac_pe_acc #(.DATA_W(8), .ACC_W(24), .SHIFT_W(5)) dut (
        .clk_i(clk), .rst_i(rst_i), .mode_os_i(mode_os_i), .load_w_i(load_w_i),
        .clear_acc_i(clear_acc_i), .drain_i(drain_i), .sat_en_i(sat_en_i), .shift_i(shift_i),
        .north_i(north_i), .north_valid_i(north_valid_i), .west_i(west_i),
        .west_valid_i(west_valid_i), .psum_i(psum_i), .psum_valid_i(psum_valid_i),
        .east_o(east_o), .east_valid_o(east_valid_o), .south_o(south_o),
        .south_valid_o(south_valid_o), .psum_o(psum_o), .psum_valid_o(psum_valid_o),
        .result_o(result_o), .result_valid_o(result_valid_o), .ovf_o(ovf_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic mode, ld, clr, drn, sat;
        logic [4:0] sh;
        logic signed [7:0] n;  logic nv;
        logic signed [7:0] w;  logic wv;
        logic signed [23:0] p; logic pv;
        logic signed [7:0] e;  logic ev;
        logic signed [7:0] s;  logic sv;
        logic signed [23:0] po; logic pov;
        logic signed [7:0] r;  logic rv;
        logic ovf;
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic mode, ld, clr, drn, sat, input int sh,
                                input int n, input logic nv, input int w, input logic wv,
                                input int p, input logic pv, input int e, input logic ev,
                                input int s, input logic sv, input int po, input logic pov,
                                input int r, input logic rv, input logic ovf);
        vec_t v;
        v.mode = mode; v.ld = ld; v.clr = clr; v.drn = drn; v.sat = sat; v.sh = 5'(sh);
        v.n = 8'(n); v.nv = nv; v.w = 8'(w); v.wv = wv; v.p = 24'(p); v.pv = pv;
        v.e = 8'(e); v.ev = ev; v.s = 8'(s); v.sv = sv; v.po = 24'(po); v.pov = pov;
        v.r = 8'(r); v.rv = rv; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string name, input logic signed [31:0] act, input logic signed [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chk_all(input string tag, input int e, ev, s, sv, po, pov, r, rv, ovf);
        chk({tag, ".east"}, $signed(east_o), e);
        chk({tag, ".east_v"}, 32'(east_valid_o), ev);
        chk({tag, ".south"}, $signed(south_o), s);
        chk({tag, ".south_v"}, 32'(south_valid_o), sv);
        chk({tag, ".psum"}, $signed(psum_o), po);
        chk({tag, ".psum_v"}, 32'(psum_valid_o), pov);
        chk({tag, ".result"}, $signed(result_o), r);
        chk({tag, ".result_v"}, 32'(result_valid_o), rv);
        chk({tag, ".ovf"}, 32'(ovf_o), ovf);
    endtask

    // One output-stationary cycle; psum chain carries a dummy beat alongside each fire.
    task automatic os_step(input logic clr, drn, sat, input int sh, input int n, w, input logic fire);
        mode_os_i = 1'b1; load_w_i = 1'b0; clear_acc_i = clr; drain_i = drn; sat_en_i = sat;
        shift_i = 5'(sh); north_i = 8'(n); west_i = 8'(w);
        north_valid_i = fire; west_valid_i = fire; psum_i = 24'd9; psum_valid_i = fire;
        @(posedge clk); #1;
    endtask

    initial begin
        rst_i = 1'b1; mode_os_i = 0; load_w_i = 0; clear_acc_i = 0; drain_i = 0; sat_en_i = 0;
        shift_i = 0; north_i = 0; west_i = 0; north_valid_i = 0; west_valid_i = 0;
        psum_i = 0; psum_valid_i = 0;
        repeat (2) @(posedge clk);
        #1;
        chk_all("reset", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;

        // Weight-stationary
        vt.push_back(mk(0,1,0,0,0,0, -3,1, 0,0, 0,0,            0,0, -3,1, 0,0,        0,0, 0));
        vt.push_back(mk(0,0,0,0,0,0, 0,0, 100,1, 50,1,          100,1, 0,0, -250,1,    0,0, 0));
        vt.push_back(mk(0,1,0,1,1,2, 5,0, 10,1, 1000,1,         10,1, 5,0, 970,1,      127,1, 1));
        vt.push_back(mk(0,0,0,1,0,0, 0,0, 0,0, 0,0,             0,0, 0,0, 970,0,       127,0, 1));
        vt.push_back(mk(0,0,1,0,0,0, 0,0, 0,0, 0,0,             0,0, 0,0, 970,0,       127,0, 0));
        vt.push_back(mk(0,0,0,0,0,0, 0,0, -128,1, 8388607,1,    -128,1, 0,0, 8388607,1, 127,0, 1));
        vt.push_back(mk(0,0,1,0,0,0, 0,0, -128,1, -8388608,1,   -128,1, 0,0, -8388224,1, 127,0, 0));
        vt.push_back(mk(0,0,0,1,1,0, 0,0, 2,1, 3,1,             2,1, 0,0, -3,1,        -3,1, 0));
        // Output-stationary: 4 x 127*127 = 64516
        vt.push_back(mk(1,0,1,0,0,0, 0,0, 0,0, 0,0,             0,0, 0,0, 0,0,         -3,0, 0));
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(1,0,0,0,0,0, 127,1, 127,1, 7,1,     127,1, 127,1, 7,1,     -3,0, 0));
        vt.push_back(mk(1,0,0,1,1,10, 0,0, 0,0, 0,0,            0,0, 0,0, 0,0,         63,1, 0));
        for (int k = 0; k < 4; k++)
            vt.push_back(mk(1,0,0,0,0,0, 127,1, 127,1, 0,0,     127,1, 127,1, 0,0,     63,0, 0));
        vt.push_back(mk(1,0,0,1,1,8, 0,0, 0,0, 0,0,             0,0, 0,0, 0,0,         127,1, 1));
        vt.push_back(mk(1,0,1,0,0,0, 0,0, 0,0, 0,0,             0,0, 0,0, 0,0,         127,0, 0));

        foreach (vt[i]) begin
            mode_os_i = vt[i].mode; load_w_i = vt[i].ld; clear_acc_i = vt[i].clr;
            drain_i = vt[i].drn; sat_en_i = vt[i].sat; shift_i = vt[i].sh;
            north_i = vt[i].n; north_valid_i = vt[i].nv; west_i = vt[i].w;
            west_valid_i = vt[i].wv; psum_i = vt[i].p; psum_valid_i = vt[i].pv;
            @(posedge clk); #1;
            chk_all($sformatf("v%0d", i), vt[i].e, 32'(vt[i].ev), vt[i].s, 32'(vt[i].sv),
                    vt[i].po, 32'(vt[i].pov), vt[i].r, 32'(vt[i].rv), 32'(vt[i].ovf));
        end

        // Accumulator saturation: 512th product of 16384 crosses 2^23-1
        for (int k = 0; k < 511; k++) os_step(0, 0, 0, 0, -128, -128, 1);
        chk("acc_sat.ovf_before", 32'(ovf_o), 0);
        os_step(0, 0, 0, 0, -128, -128, 1);
        os_step(0, 0, 0, 0, -128, -128, 1);
        chk("acc_sat.ovf", 32'(ovf_o), 1);
        os_step(0, 1, 0, 0, 0, 0, 0);
        chk("acc_sat.low_byte", $signed(result_o), -1);
        chk("acc_sat.ovf_held", 32'(ovf_o), 1);
        os_step(1, 0, 0, 0, 0, 0, 0);
        chk("acc_sat.ovf_clr", 32'(ovf_o), 0);
        os_step(0, 1, 0, 0, 0, 0, 0);
        chk("acc_sat.acc_zero", $signed(result_o), 0);
        chk("acc_sat.rv", 32'(result_valid_o), 1);

        // Drain + fire in the same cycle
        os_step(1, 0, 0, 0, 100, 10, 1);
        os_step(0, 1, 1, 0, 2, 3, 1);
        chk("dfire.sat_result", $signed(result_o), 127);
        chk("dfire.sat_ovf", 32'(ovf_o), 1);
        os_step(0, 1, 0, 0, 0, 0, 0);
        chk("dfire.next_acc", $signed(result_o), 6);
        os_step(1, 0, 0, 0, 100, 10, 1);
        chk("dfire.clr_ovf", 32'(ovf_o), 0);
        os_step(0, 1, 0, 0, 2, 3, 1);
        chk("dfire.trunc_result", $signed(result_o), -24);
        chk("dfire.trunc_ovf", 32'(ovf_o), 0);
        os_step(0, 1, 0, 0, 0, 0, 0);
        chk("dfire.next_acc2", $signed(result_o), 6);

        // Round half up
        os_step(0, 0, 0, 0, -5, 1, 1);
        os_step(0, 1, 1, 1, 0, 0, 0);
        chk("round.neg", $signed(result_o), -2);
        os_step(0, 0, 0, 0, 5, 1, 1);
        os_step(0, 1, 1, 1, 0, 0, 0);
        chk("round.pos", $signed(result_o), 3);

        // Reset mid-accumulate
        os_step(0, 0, 0, 0, 10, 10, 1);
        os_step(0, 0, 0, 0, 10, 10, 1);
        rst_i = 1'b1;
        os_step(0, 0, 0, 0, 10, 10, 1);
        chk_all("rst_mid", 0, 0, 0, 0, 0, 0, 0, 0, 0);
        rst_i = 1'b0;
        os_step(0, 1, 0, 0, 0, 0, 0);
        chk("rst_mid.acc", $signed(result_o), 0);
        chk("rst_mid.rv", 32'(result_valid_o), 1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
